pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the port directions and widths below.
REQ-002 Ports (name, direction, width, meaning):
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- insn_f, input, 32: instruction fetched this cycle.
- pc_f, input, 32: PC of insn_f.
- flush_x, input, 1: branch/jump taken in X; squash younger instructions.
- md_ready, input, 1: multdiv result valid (single-cycle pulse).
- fd_insn, output, 32: F/D instruction register.
- fd_pc, output, 32: F/D PC register.
- dx_insn, output, 32: D/X instruction register.
- dx_pc, output, 32: D/X PC register.
- pc_we, output, 1: PC write enable (0 = hold fetch).
- md_start, output, 1: start pulse to multdiv.
- md_active, output, 1: multdiv operation outstanding.
- stall, output, 1: any hold condition this cycle.

Function
REQ-003 Field decode SHALL be: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]. NOP = 32'h0000_0000.
REQ-004 load_use SHALL be 1 when all of the following hold:
- dx opcode = 01000 (lw);
- fd rs = dx rd, or fd rt = dx rd;
- fd opcode != 00111 (sw).
There SHALL be no exemption for register 0.
REQ-005 is_md SHALL be 1 when dx opcode = 00000 and aluop is 00110 (mul) or 00111 (div).
REQ-006 FSM states SHALL be RUN and MD_WAIT.
- RUN -> MD_WAIT: at an edge where is_md=1 and flush_x=0.
- MD_WAIT -> RUN: at an edge where md_ready=1.
REQ-007 md_start SHALL be combinational: 1 exactly when state=RUN, is_md=1 and flush_x=0. It is therefore asserted for one cycle per mul/div.
REQ-008 md_active SHALL be 1 when state=MD_WAIT.
REQ-009 freeze SHALL be md_start OR (state=MD_WAIT AND md_ready=0).
REQ-010 Per-edge update SHALL follow this priority, first match wins:
- (a) flush_x=1 in RUN: fd_insn<=NOP, dx_insn<=NOP, PCs<=0, pc_we=1.
- (b) freeze=1: fd and dx registers hold, pc_we=0.
- (c) load_use=1: fd holds, dx_insn<=NOP, dx_pc<=0, pc_we=0.
- (d) otherwise: fd<=insn_f/pc_f, dx<=fd_insn/fd_pc, pc_we=1.
REQ-011 flush_x SHALL be ignored in MD_WAIT.
REQ-012 When md_ready=1 in MD_WAIT, the pipeline SHALL advance at that edge under rule (c) or (d). The mul/div SHALL leave DX and SHALL NOT restart.
REQ-013 stall SHALL equal freeze OR (load_use AND NOT flush_x). pc_we SHALL equal NOT stall, except pc_we=1 under flush.
REQ-014 A load-use stall SHALL last exactly one cycle, because the following bubble clears the dx-rd match.
REQ-015 md_ready arriving in RUN SHALL be ignored.

Reset
REQ-016 While reset_n=0, asynchronously:
- fd_insn, fd_pc, dx_insn and dx_pc SHALL be 0;
- state SHALL be RUN.
Combinational outputs then follow: md_start=0, md_active=0, stall=0, pc_we=1.
REQ-017 Reset asserted in MD_WAIT SHALL abandon the operation. No md_start SHALL follow until a new mul/div reaches DX.

Structure
REQ-018 A shared package SHALL hold:
- opcode constants (ALU 00000, LW 01000, SW 00111);
- aluop constants (MUL 00110, DIV 00111);
- the NOP constant;
- the field bit positions;
- the state enum.
REQ-019 load_use SHALL be a separate combinational sub-module, load_use_detect, with inputs fd_insn and dx_insn and output load_use. The FSM and registers SHALL be in pipe_hazard_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load-use: dx=lw r5, fd=add r6,r5,r2 -> stall=1 and pc_we=0 for 1 cycle; dx becomes NOP; next cycle add enters dx.
- Store exemption: dx=lw r5, fd=sw r5 -> stall=0; normal advance.
- Mul handshake: mul enters dx -> md_start=1 for 1 cycle; md_active=1; stall=1; md_ready pulsed 4 cycles later -> mul leaves dx at that edge; md_start stays 0.
- Flush priority: flush_x=1 with load_use=1 -> fd_insn=dx_insn=0 next edge; pc_we=1; stall=0.
- Reset mid-MD_WAIT: reset_n=0 -> all registers 0 and md_active=0 immediately; a late md_ready after release -> no effect.
- Flush with is_md: flush_x=1 while mul is in dx -> md_start=0; state stays RUN; dx=NOP.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings, field positions and FSM states for pipe_hazard_ctrl
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] OPC_ALU = 5'b00000;
  localparam logic [4:0] OPC_LW  = 5'b01000;
  localparam logic [4:0] OPC_SW  = 5'b00111;

  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  localparam int RD_MSB    = 26;
  localparam int RD_LSB    = 22;
  localparam int RS_MSB    = 21;
  localparam int RS_LSB    = 17;
  localparam int RT_MSB    = 16;
  localparam int RT_LSB    = 12;
  localparam int ALUOP_MSB = 6;
  localparam int ALUOP_LSB = 2;

  typedef enum logic {
    RUN,
    MD_WAIT
  } hazState_e;

  function automatic logic [4:0] fieldOpcode(input logic [31:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] fieldRd(input logic [31:0] insn);
    return insn[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] fieldRs(input logic [31:0] insn);
    return insn[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] fieldRt(input logic [31:0] insn);
    return insn[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] fieldAluop(input logic [31:0] insn);
    return insn[ALUOP_MSB:ALUOP_LSB];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// rtl/pipe_hazard_ctrl_load_use_detect.sv - combinational lw-to-consumer hazard detect between F/D and D/X
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  output logic        load_use
);

  logic dxIsLoad;
  logic srcMatch;
  logic fdIsStore;
  logic unusedBits;

  assign dxIsLoad  = (fieldOpcode(dx_insn) == OPC_LW);
  // r0 is deliberately not exempt: a match on register 0 still stalls
  assign srcMatch  = (fieldRs(fd_insn) == fieldRd(dx_insn)) ||
                     (fieldRt(fd_insn) == fieldRd(dx_insn));
  assign fdIsStore = (fieldOpcode(fd_insn) == OPC_SW);

  assign load_use = dxIsLoad && srcMatch && !fdIsStore;

  assign unusedBits = ^{fd_insn[RD_MSB:RD_LSB], fd_insn[RT_LSB-1:0], dx_insn[RS_MSB:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - F/D and D/X pipeline registers with load-use, flush and mul/div hold control
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn_f,
  input  logic [31:0] pc_f,
  input  logic        flush_x,
  input  logic        md_ready,
  output logic [31:0] fd_insn,
  output logic [31:0] fd_pc,
  output logic [31:0] dx_insn,
  output logic [31:0] dx_pc,
  output logic        pc_we,
  output logic        md_start,
  output logic        md_active,
  output logic        stall
);

  hazState_e state;
  hazState_e nextState;

  logic loadUse;
  logic isMd;
  logic freeze;
  logic flushRun;

  load_use_detect uLoadUse (
    .fd_insn  (fd_insn),
    .dx_insn  (dx_insn),
    .load_use (loadUse)
  );

  assign isMd = (fieldOpcode(dx_insn) == OPC_ALU) &&
                ((fieldAluop(dx_insn) == ALUOP_MUL) || (fieldAluop(dx_insn) == ALUOP_DIV));

  // A flush only means something while the pipe is running; in MD_WAIT it is dropped
  assign flushRun  = flush_x && (state == RUN);
  assign md_start  = (state == RUN) && isMd && !flush_x;
  assign md_active = (state == MD_WAIT);
  assign freeze    = md_start || ((state == MD_WAIT) && !md_ready);
  assign stall     = freeze || (loadUse && !flush_x);

  always_comb begin
    pc_we = 1'b1;
    if (flushRun) begin
      pc_we = 1'b1;
    end else if (freeze || loadUse) begin
      pc_we = 1'b0;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (isMd && !flush_x) nextState = MD_WAIT;
      MD_WAIT: if (md_ready) nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fd_insn <= NOP;
      fd_pc   <= '0;
      dx_insn <= NOP;
      dx_pc   <= '0;
    end else if (flushRun) begin
      fd_insn <= NOP;
      fd_pc   <= '0;
      dx_insn <= NOP;
      dx_pc   <= '0;
    end else if (freeze) begin
      fd_insn <= fd_insn;
      fd_pc   <= fd_pc;
      dx_insn <= dx_insn;
      dx_pc   <= dx_pc;
    end else if (loadUse) begin
      // Bubble into D/X; the consumer waits one cycle in F/D
      dx_insn <= NOP;
      dx_pc   <= '0;
    end else begin
      fd_insn <= insn_f;
      fd_pc   <= pc_f;
      dx_insn <= fd_insn;
      dx_pc   <= fd_pc;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed hazard scenarios
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] insn_f = '0;
  logic [31:0] pc_f = '0;
  logic        flush_x = 1'b0;
  logic        md_ready = 1'b0;
  logic [31:0] fd_insn, fd_pc, dx_insn, dx_pc;
  logic        pc_we, md_start, md_active, stall;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] fdI;
    logic [31:0] fdP;
    logic [31:0] dxI;
    logic [31:0] dxP;
    logic        pcWe;
    logic        stl;
    logic        mdS;
    logic        mdA;
  } expect_t;

  expect_t expQ[$];

  pipe_hazard_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .insn_f    (insn_f),
    .pc_f      (pc_f),
    .flush_x   (flush_x),
    .md_ready  (md_ready),
    .fd_insn   (fd_insn),
    .fd_pc     (fd_pc),
    .dx_insn   (dx_insn),
    .dx_pc     (dx_pc),
    .pc_we     (pc_we),
    .md_start  (md_start),
    .md_active (md_active),
    .stall     (stall)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] aluop);
    return {op, rd, rs, rt, 5'b0, aluop, 2'b0};
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      chk(e.name, "fd_insn", fd_insn, e.fdI);
      chk(e.name, "fd_pc", fd_pc, e.fdP);
      chk(e.name, "dx_insn", dx_insn, e.dxI);
      chk(e.name, "dx_pc", dx_pc, e.dxP);
      chk(e.name, "pc_we", {31'b0, pc_we}, {31'b0, e.pcWe});
      chk(e.name, "stall", {31'b0, stall}, {31'b0, e.stl});
      chk(e.name, "md_start", {31'b0, md_start}, {31'b0, e.mdS});
      chk(e.name, "md_active", {31'b0, md_active}, {31'b0, e.mdA});
    end
  end

  task automatic step(input string nm, input logic rn, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic mr,
                      input logic [31:0] eFdI, input logic [31:0] eFdP,
                      input logic [31:0] eDxI, input logic [31:0] eDxP,
                      input logic ePcWe, input logic eStall, input logic eMdS, input logic eMdA);
    expect_t e;
    @(posedge clock);
    #1;
    reset_n  = rn;
    insn_f   = ins;
    pc_f     = pc;
    flush_x  = fl;
    md_ready = mr;
    e.name = nm; e.fdI = eFdI; e.fdP = eFdP; e.dxI = eDxI; e.dxP = eDxP;
    e.pcWe = ePcWe; e.stl = eStall; e.mdS = eMdS; e.mdA = eMdA;
    expQ.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lw5, add6, add7, sw5, mul1, addA1, addA2, lw9, add10, div1, mul3;
    lw5   = mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0);
    add6  = mk(5'd0, 5'd6, 5'd5, 5'd2, 5'd0);
    add7  = mk(5'd0, 5'd7, 5'd1, 5'd1, 5'd0);
    sw5   = mk(5'd7, 5'd5, 5'd5, 5'd0, 5'd0);
    mul1  = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd6);
    addA1 = mk(5'd0, 5'd4, 5'd1, 5'd1, 5'd0);
    addA2 = mk(5'd0, 5'd8, 5'd1, 5'd1, 5'd0);
    lw9   = mk(5'd8, 5'd9, 5'd1, 5'd0, 5'd0);
    add10 = mk(5'd0, 5'd10, 5'd9, 5'd1, 5'd0);
    div1  = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd7);
    mul3  = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd6);

    //   name          rn insn   pc        fl mr  fdI    fdP       dxI    dxP       we st ms ma
    step("reset",      0, 0,     0,        0, 0,  0,     0,        0,     0,        1, 0, 0, 0);
    // load-use
    step("lu_s1",      1, lw5,   32'h100,  0, 0,  0,     0,        0,     0,        1, 0, 0, 0);
    step("lu_s2",      1, add6,  32'h104,  0, 0,  lw5,   32'h100,  0,     0,        1, 0, 0, 0);
    step("lu_stall",   1, add7,  32'h108,  0, 0,  add6,  32'h104,  lw5,   32'h100,  0, 1, 0, 0);
    step("lu_bubble",  1, add7,  32'h108,  0, 0,  add6,  32'h104,  0,     0,        1, 0, 0, 0);
    step("lu_adv",     1, 0,     32'h10c,  0, 0,  add7,  32'h108,  add6,  32'h104,  1, 0, 0, 0);
    // store exemption
    step("sw_s1",      1, lw5,   32'h200,  0, 0,  0,     32'h10c,  add7,  32'h108,  1, 0, 0, 0);
    step("sw_s2",      1, sw5,   32'h204,  0, 0,  lw5,   32'h200,  0,     32'h10c,  1, 0, 0, 0);
    step("sw_exempt",  1, 0,     32'h208,  0, 0,  sw5,   32'h204,  lw5,   32'h200,  1, 0, 0, 0);
    step("sw_adv",     1, 0,     32'h20c,  0, 0,  0,     32'h208,  sw5,   32'h204,  1, 0, 0, 0);
    // mul handshake
    step("md_s1",      1, mul1,  32'h300,  0, 0,  0,     32'h20c,  0,     32'h208,  1, 0, 0, 0);
    step("md_s2",      1, addA1, 32'h304,  0, 0,  mul1,  32'h300,  0,     32'h20c,  1, 0, 0, 0);
    step("md_start",   1, addA2, 32'h308,  0, 0,  addA1, 32'h304,  mul1,  32'h300,  0, 1, 1, 0);
    step("md_wait1",   1, addA2, 32'h308,  0, 0,  addA1, 32'h304,  mul1,  32'h300,  0, 1, 0, 1);
    step("md_wait2",   1, addA2, 32'h308,  1, 0,  addA1, 32'h304,  mul1,  32'h300,  0, 1, 0, 1);
    step("md_wait3",   1, addA2, 32'h308,  0, 0,  addA1, 32'h304,  mul1,  32'h300,  0, 1, 0, 1);
    step("md_ready",   1, addA2, 32'h308,  0, 1,  addA1, 32'h304,  mul1,  32'h300,  1, 0, 0, 1);
    step("md_done",    1, 0,     32'h30c,  0, 0,  addA2, 32'h308,  addA1, 32'h304,  1, 0, 0, 0);
    // flush beats load-use
    step("fl_s1",      1, lw9,   32'h400,  0, 0,  0,     32'h30c,  addA2, 32'h308,  1, 0, 0, 0);
    step("fl_s2",      1, add10, 32'h404,  0, 0,  lw9,   32'h400,  0,     32'h30c,  1, 0, 0, 0);
    step("fl_lu",      1, 0,     32'h408,  1, 0,  add10, 32'h404,  lw9,   32'h400,  1, 0, 0, 0);
    step("fl_after",   1, 0,     32'h500,  0, 0,  0,     0,        0,     0,        1, 0, 0, 0);
    // flush with mul/div in D/X
    step("fm_s1",      1, div1,  32'h600,  0, 0,  0,     32'h500,  0,     0,        1, 0, 0, 0);
    step("fm_s2",      1, 0,     32'h604,  0, 0,  div1,  32'h600,  0,     32'h500,  1, 0, 0, 0);
    step("fm_flush",   1, 0,     32'h608,  1, 0,  0,     32'h604,  div1,  32'h600,  1, 0, 0, 0);
    step("fm_after",   1, 0,     32'h700,  0, 0,  0,     0,        0,     0,        1, 0, 0, 0);
    // reset while in MD_WAIT
    step("rm_s1",      1, mul3,  32'h800,  0, 0,  0,     32'h700,  0,     0,        1, 0, 0, 0);
    step("rm_s2",      1, 0,     32'h804,  0, 0,  mul3,  32'h800,  0,     32'h700,  1, 0, 0, 0);
    step("rm_start",   1, 0,     32'h808,  0, 0,  0,     32'h804,  mul3,  32'h800,  0, 1, 1, 0);
    step("rm_wait",    1, 0,     32'h808,  0, 0,  0,     32'h804,  mul3,  32'h800,  0, 1, 0, 1);
    step("rm_reset",   0, 0,     32'h808,  0, 0,  0,     0,        0,     0,        1, 0, 0, 0);
    step("rm_late_rdy",1, 0,     32'h900,  0, 1,  0,     0,        0,     0,        1, 0, 0, 0);
    step("rm_after",   1, 0,     32'h904,  0, 0,  0,     32'h900,  0,     0,        1, 0, 0, 0);

    repeat (3) @(negedge clock);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
